// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package mips_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULTU = 2'd0,
    MD_MULT  = 2'd1,
    MD_DIVU  = 2'd2,
    MD_DIV   = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int unsigned WIDTH = mips_pkg::MD_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_1;
  logic [WIDTH-1:0] src_2;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_1, src_2, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_1, src_2, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate: operand magnitudes on entry, result signs on FIX.
module md_sign_fix
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH-1:0] wide_i,
  input  logic               wide_neg_i,
  input  logic [WIDTH-1:0]   narrow_i,
  input  logic               narrow_neg_i,
  output logic [2*WIDTH-1:0] wide_o,
  output logic [WIDTH-1:0]   narrow_o
);

  assign wide_o   = wide_neg_i   ? -wide_i   : wide_i;
  assign narrow_o = narrow_neg_i ? -narrow_i : narrow_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Bit-serial MULT/MULTU/DIV/DIVU into HI/LO; one iteration per cycle, busy stalls the pipe.
module ex_muldiv_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  ex_muldiv_unit_if.slave   md_if
);

  localparam int unsigned CntW = $clog2(WIDTH);

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               done_q, done_d;

  md_op_e op_in;
  logic   in_signed, in_div, a_neg, b_neg, b_zero, op_div_q;
  assign op_in     = md_op_e'(md_if.op);
  assign in_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
  assign in_div    = (op_in == MD_DIVU) || (op_in == MD_DIV);
  assign a_neg     = in_signed & md_if.src_1[WIDTH-1];
  assign b_neg     = in_signed & md_if.src_2[WIDTH-1];
  assign b_zero    = (md_if.src_2 == '0);
  assign op_div_q  = (op_q == MD_DIVU) || (op_q == MD_DIV);

  logic [2*WIDTH-1:0] fix_wide_in, fix_wide_out;
  logic [WIDTH-1:0]   fix_narrow_in, fix_narrow_out;
  logic               fix_wide_neg, fix_narrow_neg;

  // Entry feeds operands for abs; FIX feeds the result (product, or quotient + remainder).
  always_comb begin
    fix_wide_in    = {{WIDTH{1'b0}}, md_if.src_1};
    fix_wide_neg   = a_neg;
    fix_narrow_in  = md_if.src_2;
    fix_narrow_neg = b_neg;
    if (state_q == MD_FIX) begin
      fix_wide_neg   = res_neg_q;
      fix_narrow_in  = acc_q[2*WIDTH-1:WIDTH];
      fix_narrow_neg = rem_neg_q;
      fix_wide_in    = op_div_q ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;
    end
  end

  md_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .wide_i       (fix_wide_in),
    .wide_neg_i   (fix_wide_neg),
    .narrow_i     (fix_narrow_in),
    .narrow_neg_i (fix_narrow_neg),
    .wide_o       (fix_wide_out),
    .narrow_o     (fix_narrow_out)
  );

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, quotient}; restoring shift-subtract.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = rem_sh >= {1'b0, opnd_q};
  assign div_diff = rem_sh[WIDTH-1:0] - opnd_q;
  assign div_next = {(div_ge ? div_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    done_d    = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (md_if.start) begin
          op_d      = op_in;
          count_d   = '0;
          // Divide-by-zero keeps quotient all-ones and remainder = raw dividend.
          res_neg_d = (a_neg ^ b_neg) & ~(in_div & b_zero);
          rem_neg_d = in_div & a_neg;
          acc_d     = {{WIDTH{1'b0}}, (in_div ? fix_wide_out[WIDTH-1:0] : fix_narrow_out)};
          opnd_d    = in_div ? fix_narrow_out : fix_wide_out[WIDTH-1:0];
          state_d   = MD_RUN;
        end else begin
          if (md_if.mthi) hi_d = md_if.src_1;
          if (md_if.mtlo) lo_d = md_if.src_1;
        end
      end
      MD_RUN: begin
        acc_d   = op_div_q ? div_next : mul_next;
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        hi_d    = op_div_q ? fix_narrow_out : fix_wide_out[2*WIDTH-1:WIDTH];
        lo_d    = fix_wide_out[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_MULTU;
      count_q   <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      done_q    <= done_d;
    end
  end

  assign md_if.busy = (state_q != MD_IDLE);
  assign md_if.done = done_q;
  assign md_if.hi   = hi_q;
  assign md_if.lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed checks of ex_muldiv_unit: latency, signed rules, MT writes, start collisions, reset abort.
module tb_ex_muldiv_unit;
  import mips_pkg::*;

  logic clk_i = 1'b0;
  logic rst_n_i;
  always #5 clk_i = ~clk_i;

  ex_muldiv_unit_if #(.WIDTH(32)) md_if ();

  ex_muldiv_unit #(
    .WIDTH (32)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .md_if   (md_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    md_if.start = 1'b0;
    md_if.op    = 2'd0;
    md_if.src_1 = '0;
    md_if.src_2 = '0;
    md_if.mthi  = 1'b0;
    md_if.mtlo  = 1'b0;
  endtask

  task automatic mt_write(input logic hi_wr, input logic lo_wr, input logic [31:0] val,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string tag);
    @(negedge clk_i);
    md_if.mthi  = hi_wr;
    md_if.mtlo  = lo_wr;
    md_if.src_1 = val;
    @(posedge clk_i);
    #1;
    md_if.mthi = 1'b0;
    md_if.mtlo = 1'b0;
    check_eq({tag, "_hi"}, md_if.hi, exp_hi);
    check_eq({tag, "_lo"}, md_if.lo, exp_lo);
    @(negedge clk_i);
    check_eq({tag, "_nodone"}, {31'd0, md_if.done}, 32'd0);
  endtask

  // restart_at > 0 raises start again at that busy cycle with a different op.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mtlo, input int restart_at,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string tag);
    int          busy_cycles = 0;
    int          done_seen   = 0;
    bit          finished    = 0;
    logic [31:0] hi_before, lo_before;
    @(negedge clk_i);
    hi_before   = md_if.hi;
    lo_before   = md_if.lo;
    md_if.start = 1'b1;
    md_if.op    = op;
    md_if.src_1 = a;
    md_if.src_2 = b;
    md_if.mtlo  = mtlo;
    @(posedge clk_i);
    #1;
    md_if.start = 1'b0;
    md_if.mtlo  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      md_if.start = 1'b0;
      if (md_if.busy) busy_cycles++;
      if (md_if.done) done_seen++;
      if (i == 17) begin
        check_eq({tag, "_hold_hi"}, md_if.hi, hi_before);
        check_eq({tag, "_hold_lo"}, md_if.lo, lo_before);
      end
      if (i == restart_at) begin
        md_if.start = 1'b1;
        md_if.op    = MD_DIVU;
      end
      if (!md_if.busy) begin
        finished = 1;
        break;
      end
    end
    check_eq({tag, "_finished"}, {31'd0, finished}, 32'd1);
    check_eq({tag, "_busy_cycles"}, busy_cycles, 32'd33);
    check_eq({tag, "_done_pulses"}, done_seen, 32'd1);
    check_eq({tag, "_hi"}, md_if.hi, exp_hi);
    check_eq({tag, "_lo"}, md_if.lo, exp_lo);
    @(negedge clk_i);
    check_eq({tag, "_done_low"}, {31'd0, md_if.done}, 32'd0);
  endtask

  initial begin
    int done_seen;
    int busy_seen;
    idle_inputs();
    rst_n_i = 1'b0;
    #12;
    check_eq("rst_busy", {31'd0, md_if.busy}, 32'd0);
    check_eq("rst_done", {31'd0, md_if.done}, 32'd0);
    check_eq("rst_hi", md_if.hi, 32'd0);
    check_eq("rst_lo", md_if.lo, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    mt_write(1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'd0, "mthi");
    run_op(MD_MULTU, 32'd2, 32'd3, 1'b1, 0, 32'd0, 32'd6, "multu_2x3_mtlo");
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0,
           32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(MD_MULT, 32'hFFFF_FFF9, 32'd3, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m7x3");
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
    run_op(MD_DIVU, 32'd100, 32'd7, 1'b0, 0, 32'd2, 32'd14, "divu_100d7");
    run_op(MD_DIVU, 32'd100, 32'd0, 1'b0, 0, 32'd100, 32'hFFFF_FFFF, "divu_by0");
    run_op(MD_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_m5_by0");
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 32'd0, 32'h8000_0000, "div_ovf");
    run_op(MD_MULTU, 32'd5, 32'd5, 1'b0, 10, 32'd0, 32'd25, "multu_5x5_restart");
    repeat (5) @(negedge clk_i);
    check_eq("post_hold_hi", md_if.hi, 32'd0);
    check_eq("post_hold_lo", md_if.lo, 32'd25);
    check_eq("post_hold_busy", {31'd0, md_if.busy}, 32'd0);

    mt_write(1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "mthilo");

    // Abort a DIVU mid-flight with an asynchronous reset.
    @(negedge clk_i);
    md_if.start = 1'b1;
    md_if.op    = MD_DIVU;
    md_if.src_1 = 32'd1000;
    md_if.src_2 = 32'd3;
    @(posedge clk_i);
    #1;
    md_if.start = 1'b0;
    repeat (15) @(negedge clk_i);
    check_eq("abort_busy_before", {31'd0, md_if.busy}, 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, md_if.busy}, 32'd0);
    check_eq("abort_hi", md_if.hi, 32'd0);
    check_eq("abort_lo", md_if.lo, 32'd0);
    @(negedge clk_i);
    rst_n_i   = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (md_if.done) done_seen++;
      if (md_if.busy) busy_seen++;
    end
    check_eq("abort_no_done", done_seen, 32'd0);
    check_eq("abort_no_busy", busy_seen, 32'd0);
    check_eq("abort_lo_stays", md_if.lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
